// File: rtl/cpu_nbit.sv
// Parametrised accumulator CPU tile: the host loads a program, pulses start and
// then samples output_data on out_valid. Adds zero/carry flags and conditional jumps.
module cpu_nbit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W+3:0] prog_data,
  output logic [DATA_W-1:0] output_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  // state | meaning
  // IDLE  | out of reset; program load allowed, waiting for start
  // FETCH | ir <= imem[pc], pc advances (wraps)
  // EXEC  | execute ir; jumps override the fetch increment
  // HALT  | HALT executed; load allowed, start reruns from pc=0
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  localparam logic [3:0] OP_LOAD_A = 4'h1;
  localparam logic [3:0] OP_LOAD_B = 4'h2;
  localparam logic [3:0] OP_ADD    = 4'h3;
  localparam logic [3:0] OP_JMP    = 4'h4;
  localparam logic [3:0] OP_OUT    = 4'h5;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_JZ     = 4'h7;
  localparam logic [3:0] OP_JC     = 4'h8;
  localparam logic [3:0] OP_MOV_BA = 4'h9;
  localparam logic [3:0] OP_HALT   = 4'hF;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W+3:0]   ir;
  logic [DATA_W-1:0]   reg_a;
  logic [DATA_W-1:0]   reg_b;
  logic                zero;
  logic                carry;
  logic [DATA_W+3:0]   imem [2**ADDR_W];

  logic [3:0]          opcode;
  logic [DATA_W-1:0]   operand;
  logic [ADDR_W-1:0]   target;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic                idle_like;

  assign opcode    = ir[DATA_W+3:DATA_W];
  assign operand   = ir[DATA_W-1:0];
  assign target    = operand[ADDR_W-1:0];
  assign sum       = {1'b0, reg_a} + {1'b0, reg_b};
  // Top bit of the widened difference is the borrow (set when A < B).
  assign diff      = {1'b0, reg_a} - {1'b0, reg_b};
  assign idle_like = (state == IDLE) || (state == HALT);
  assign halted    = idle_like;
  assign pc_out    = pc;

  // Program memory has no reset so a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (prog_we && idle_like) begin
      imem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      ir          <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      zero        <= 1'b0;
      carry       <= 1'b0;
      output_data <= '0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc    <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          ir    <= imem[pc];
          pc    <= pc + ADDR_W'(1);
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          case (opcode)
            OP_LOAD_A: reg_a <= operand;
            OP_LOAD_B: reg_b <= operand;
            OP_ADD: begin
              {carry, reg_a} <= sum;
              zero           <= (sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              {carry, reg_a} <= diff;
              zero           <= (diff[DATA_W-1:0] == '0);
            end
            OP_JMP: pc <= target;
            OP_OUT: begin
              output_data <= reg_a;
              out_valid   <= 1'b1;
            end
            OP_JZ: begin
              if (zero) pc <= target;
            end
            OP_JC: begin
              if (carry) pc <= target;
            end
            OP_MOV_BA: reg_b <= reg_a;
            OP_HALT:   state <= HALT;
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_nbit.sv
// Bench for cpu_nbit: directed programs plus random programs checked cycle by
// cycle against an instruction-level model of the CPU.
module tb_cpu_nbit;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int IW    = DW + 4;
  localparam int DEPTH = 1 << AW;
  localparam int MAXC  = 80;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [DW-1:0] output_data;
  logic          out_valid;
  logic          halted;
  logic [AW-1:0] pc_out;

  logic          start2;
  logic          prog_we2;
  logic [1:0]    prog_addr2;
  logic [IW-1:0] prog_data2;
  logic [DW-1:0] output_data2;
  logic          out_valid2;
  logic          halted2;
  logic [1:0]    pc_out2;

  cpu_nbit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .output_data(output_data),
    .out_valid(out_valid), .halted(halted), .pc_out(pc_out)
  );

  cpu_nbit #(.DATA_W(DW), .ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .prog_we(prog_we2),
    .prog_addr(prog_addr2), .prog_data(prog_data2), .output_data(output_data2),
    .out_valid(out_valid2), .halted(halted2), .pc_out(pc_out2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int m_mem [DEPTH];
  int m_a, m_b, m_z, m_c, m_out;
  bit e_valid [MAXC+1];
  int e_data  [MAXC+1];
  bit e_halt  [MAXC+1];
  int e_pc    [MAXC+1];
  int seen_out [$];

  task automatic model_reset();
    m_a = 0; m_b = 0; m_z = 0; m_c = 0; m_out = 0;
  endtask

  // Instruction-level model: instruction k fetches at cycle 2k+1 and executes at 2k+2.
  task automatic model_run(input int ncyc);
    int c = 0;
    int pc = 0;
    int nxt, op, arg, r;
    bit done = 1'b0;
    for (int i = 0; i <= MAXC; i++) begin
      e_valid[i] = 1'b0; e_halt[i] = 1'b0; e_pc[i] = 0; e_data[i] = m_out;
    end
    while (!done && c + 1 <= ncyc) begin
      op  = m_mem[pc] >> DW;
      arg = m_mem[pc] & 255;
      nxt = (pc + 1) % DEPTH;
      e_pc[c+1]   = nxt;
      e_data[c+1] = m_out;
      if (c + 2 > ncyc) break;
      case (op)
        1: m_a = arg;
        2: m_b = arg;
        3: begin r = m_a + m_b; m_c = (r > 255) ? 1 : 0; m_a = r % 256; m_z = (m_a == 0) ? 1 : 0; end
        4: nxt = arg % DEPTH;
        5: begin m_out = m_a; e_valid[c+2] = 1'b1; end
        6: begin m_c = (m_a < m_b) ? 1 : 0; m_a = (m_a - m_b + 256) % 256; m_z = (m_a == 0) ? 1 : 0; end
        7: if (m_z != 0) nxt = arg % DEPTH;
        8: if (m_c != 0) nxt = arg % DEPTH;
        9: m_b = m_a;
        15: done = 1'b1;
        default: ;
      endcase
      e_pc[c+2]   = nxt;
      e_data[c+2] = m_out;
      if (done) begin
        for (int j = c + 2; j <= ncyc; j++) begin
          e_halt[j] = 1'b1; e_pc[j] = nxt; e_data[j] = m_out;
        end
      end
      pc = nxt;
      c += 2;
    end
  endtask

  task automatic load_word(input int addr, input int op, input int arg);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = AW'(addr);
    prog_data = IW'((op << DW) | (arg & 255));
    @(negedge clk);
    prog_we = 1'b0;
    m_mem[addr] = (op << DW) | (arg & 255);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Pulses start and compares every cycle against the model; noise drives
  // random program writes while the CPU is running (they must be ignored).
  task automatic run_check(input string name, input int ncyc, input bit noise);
    model_run(ncyc);
    seen_out.delete();
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;
    for (int i = 0; i <= ncyc; i++) begin
      n_cmp++;
      if (out_valid !== e_valid[i]) begin
        n_err++;
        $display("FAIL %s out_valid cyc %0d: got %b want %b", name, i, out_valid, e_valid[i]);
      end
      n_cmp++;
      if (output_data !== DW'(e_data[i])) begin
        n_err++;
        $display("FAIL %s output_data cyc %0d: got %0d want %0d", name, i, output_data, e_data[i]);
      end
      n_cmp++;
      if (halted !== e_halt[i]) begin
        n_err++;
        $display("FAIL %s halted cyc %0d: got %b want %b", name, i, halted, e_halt[i]);
      end
      n_cmp++;
      if (pc_out !== AW'(e_pc[i])) begin
        n_err++;
        $display("FAIL %s pc_out cyc %0d: got %0d want %0d", name, i, pc_out, e_pc[i]);
      end
      if (out_valid === 1'b1) seen_out.push_back(int'(output_data));
      if (i == ncyc) begin
        n_cmp++;
        if (dut.reg_a !== DW'(m_a)) begin
          n_err++;
          $display("FAIL %s reg_a: got %0d want %0d", name, dut.reg_a, m_a);
        end
        n_cmp++;
        if (dut.zero !== (m_z != 0)) begin
          n_err++;
          $display("FAIL %s zero: got %b want %0d", name, dut.zero, m_z);
        end
        n_cmp++;
        if (dut.carry !== (m_c != 0)) begin
          n_err++;
          $display("FAIL %s carry: got %b want %0d", name, dut.carry, m_c);
        end
      end
      if (noise && !e_halt[i]) begin
        prog_we   = 1'b1;
        prog_addr = AW'($urandom_range(0, DEPTH - 1));
        prog_data = IW'($urandom);
      end else begin
        prog_we = 1'b0;
      end
      @(negedge clk);
    end
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #3;
    n_cmp++;
    if (halted !== 1'b1) begin n_err++; $display("FAIL reset halted: got %b want 1", halted); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (output_data !== 8'd0) begin n_err++; $display("FAIL reset output_data: got %0d want 0", output_data); end
    n_cmp++;
    if (pc_out !== 4'd0) begin n_err++; $display("FAIL reset pc_out: got %0d want 0", pc_out); end
    n_cmp++;
    if (halted2 !== 1'b1) begin n_err++; $display("FAIL reset halted2: got %b want 1", halted2); end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic load_add_prog();
    load_word(0, 1, 3);
    load_word(1, 2, 4);
    load_word(2, 3, 0);
    load_word(3, 5, 0);
    load_word(4, 15, 0);
  endtask

  task automatic test_add();
    load_add_prog();
    run_check("add", 14, 1'b0);
    n_cmp++;
    if (output_data !== 8'd7) begin n_err++; $display("FAIL add result: got %0d want 7", output_data); end
    n_cmp++;
    if (seen_out.size() != 1) begin n_err++; $display("FAIL add pulses: got %0d want 1", seen_out.size()); end
  endtask

  task automatic test_overflow();
    load_word(0, 1, 200);
    load_word(1, 2, 100);
    load_word(2, 3, 0);
    load_word(3, 8, 5);
    load_word(4, 15, 0);
    load_word(5, 5, 0);
    load_word(6, 15, 0);
    run_check("overflow", 16, 1'b0);
    n_cmp++;
    if (output_data !== 8'd44) begin n_err++; $display("FAIL overflow result: got %0d want 44", output_data); end
    n_cmp++;
    if (dut.carry !== 1'b1) begin n_err++; $display("FAIL overflow carry: got %b want 1", dut.carry); end
    n_cmp++;
    if (seen_out.size() != 1) begin n_err++; $display("FAIL overflow pulses: got %0d want 1", seen_out.size()); end
  endtask

  task automatic test_loop();
    load_word(0, 1, 3);
    load_word(1, 2, 1);
    load_word(2, 5, 0);
    load_word(3, 6, 0);
    load_word(4, 7, 6);
    load_word(5, 4, 2);
    load_word(6, 15, 0);
    run_check("loop", 40, 1'b0);
    n_cmp++;
    if (seen_out.size() != 3) begin
      n_err++; $display("FAIL loop pulses: got %0d want 3", seen_out.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (seen_out[k] != 3 - k) begin
          n_err++; $display("FAIL loop out[%0d]: got %0d want %0d", k, seen_out[k], 3 - k);
        end
      end
    end
    n_cmp++;
    if (dut.reg_a !== 8'd0 || dut.zero !== 1'b1 || halted !== 1'b1) begin
      n_err++; $display("FAIL loop end: got a=%0d z=%b h=%b want a=0 z=1 h=1", dut.reg_a, dut.zero, halted);
    end
  endtask

  // Restart from HALT with word 0 rewritten on the start edge; zero=1 carried over.
  task automatic test_restart();
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = IW'((7 << DW) | 6);
    m_mem[0]  = (7 << DW) | 6;
    run_check("restart", 10, 1'b0);
    n_cmp++;
    if (dut.zero !== 1'b1) begin n_err++; $display("FAIL restart zero: got %b want 1", dut.zero); end
    n_cmp++;
    if (pc_out !== 4'd7) begin n_err++; $display("FAIL restart pc: got %0d want 7", pc_out); end
    n_cmp++;
    if (output_data !== 8'd1) begin n_err++; $display("FAIL restart held out: got %0d want 1", output_data); end
  endtask

  task automatic test_reset_mid_run();
    load_add_prog();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (halted !== 1'b1) begin n_err++; $display("FAIL midreset halted: got %b want 1", halted); end
    n_cmp++;
    if (output_data !== 8'd0) begin n_err++; $display("FAIL midreset output_data: got %0d want 0", output_data); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset out_valid: got %b want 0", out_valid); end
    end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    run_check("rerun", 14, 1'b0);
    n_cmp++;
    if (output_data !== 8'd7) begin n_err++; $display("FAIL rerun result: got %0d want 7", output_data); end
  endtask

  task automatic test_wrap();
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      prog_we2 = 1'b1; prog_addr2 = 2'(a); prog_data2 = '0;
      @(negedge clk);
      prog_we2 = 1'b0;
    end
    for (int pass = 0; pass < 2; pass++) begin
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int i = 0; i <= 24; i++) begin
        n_cmp++;
        if (pc_out2 !== 2'(((i + 1) / 2) % 4)) begin
          n_err++; $display("FAIL wrap pc pass %0d cyc %0d: got %0d want %0d", pass, i, pc_out2, ((i + 1) / 2) % 4);
        end
        n_cmp++;
        if (halted2 !== 1'b0 || out_valid2 !== 1'b0) begin
          n_err++; $display("FAIL wrap run pass %0d cyc %0d: got h=%b v=%b want 0 0", pass, i, halted2, out_valid2);
        end
        prog_we2   = (pass == 0 && (i == 6 || i == 11));
        prog_addr2 = 2'd2;
        prog_data2 = IW'(15 << DW);
        @(negedge clk);
      end
      prog_we2 = 1'b0;
      pulse_reset();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      pulse_reset();
      for (int a = 0; a < DEPTH; a++) begin
        load_word(a, $urandom_range(0, 15), $urandom_range(0, 255));
      end
      run_check($sformatf("rand%0d", k), 60, k[0]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start2 = 1'b0; prog_we2 = 1'b0; prog_addr2 = '0; prog_data2 = '0;
    for (int a = 0; a < DEPTH; a++) m_mem[a] = 0;
    model_reset();
    test_reset();
    test_add();
    test_overflow();
    test_loop();
    test_restart();
    test_reset_mid_run();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_nbit.md
Name: cpu_nbit

Overview:
- Parametrised successor to the team's 4-bit accumulator CPU: configurable data width and instruction-memory depth.
- Adds an external program-load port, start/halt control, SUB and MOV instructions, zero/carry flags, conditional jumps and an output-valid strobe.
- Sits as a self-contained compute tile: a host loads a program, pulses start and samples output_data on out_valid.

Parameters:
DATA_W, 8, register/ALU/operand width in bits (must be >= ADDR_W)
ADDR_W, 4, instruction address width; memory depth = 2**ADDR_W words
(derived) INSTR_W = 4 + DATA_W; word = {opcode[3:0], operand[DATA_W-1:0]}

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  begin execution at pc=0; sampled only in IDLE or HALT
prog_we  input  1  instruction-memory write enable
prog_addr  input  ADDR_W  write address
prog_data  input  INSTR_W  write data
output_data  output  DATA_W  last value emitted by OUT
out_valid  output  1  one-cycle pulse when output_data updates
halted  output  1  high in IDLE and HALT states
pc_out  output  ADDR_W  current program counter (debug)

Behaviour:
- Reset (reset==0, async): pc=0, register_A=0, register_B=0, ir=0, zero=0, carry=0, output_data=0, out_valid=0, state=IDLE, so halted=1. Instruction memory has no reset; contents survive reset.
- Program load: write imem[prog_addr]=prog_data on a clock edge with prog_we=1, accepted only in IDLE/HALT. Ignored while running, with no side effects.
- Same-edge prog_we and start: the write lands first; execution starts next cycle and fetches the new contents.
- FSM:
  - IDLE/HALT --start--> FETCH, with pc cleared to 0.
  - FETCH: ir<=imem[pc], pc<=pc+1 (wraps modulo 2**ADDR_W); next state EXEC.
  - EXEC: executes ir; next state FETCH, or HALT for the HALT opcode.
- Timing: start sampled at edge E0; instruction n (straight-line code) executes at edge E(2n+2). Every instruction costs 2 cycles.
- Opcodes:
  - 0 NOP.
  - 1 LOAD_A: A=op.
  - 2 LOAD_B: B=op.
  - 3 ADD: {carry,A}=A+B.
  - 4 JMP: pc=op[ADDR_W-1:0].
  - 5 OUT: output_data=A, out_valid=1 for the cycle after the EXEC edge.
  - 6 SUB: A=A-B, carry=borrow (1 when A<B).
  - 7 JZ: jump to op if zero==1.
  - 8 JC: jump to op if carry==1.
  - 9 MOV_BA: B=A.
  - F HALT.
  - A-E: treated as NOP.
- Operand bits above ADDR_W are ignored for jumps.
- Flags: zero=(result==0) and carry are updated only by ADD/SUB; all other opcodes hold both flags. Arithmetic wraps modulo 2**DATA_W.
- A jump overrides the FETCH increment. JMP to the current address is a legal infinite loop.
- pc wrap: fetching the last address increments pc to 0 with no error.
- out_valid is never high for more than one consecutive cycle per OUT. output_data holds its value between OUTs.
- start while running: ignored. start in HALT: restarts at pc=0 with registers and flags retained (only reset clears them).
- Reset mid-instruction: immediate return to IDLE; any partially executed instruction has no effect after release.

Test Plan:
- DATA_W=8: load [LOAD_A 3, LOAD_B 4, ADD, OUT, HALT], pulse start at E0 -> out_valid high exactly after E8, output_data=7, zero=0, carry=0, halted=1 after E10.
- Overflow: [LOAD_A 200, LOAD_B 100, ADD, JC 5, HALT, OUT, HALT] -> output_data=44, carry=1, single out_valid pulse.
- Loop: [LOAD_A 3, LOAD_B 1, OUT, SUB, JZ 6, JMP 2, HALT] -> out_valid pulses with output_data 3, 2, 1 in order, then halted=1 with A=0, zero=1.
- Wrap/load guard: ADDR_W=2, program with no HALT (4 NOPs); pulse prog_we mid-run -> memory unchanged (verified after a later halt/reload); pc_out sequence 0,1,2,3,0 with no stall.
- Reset mid-run: assert reset between fetch and exec of OUT -> out_valid never pulses, output_data=0, halted=1 asynchronously; program still in memory, and start reruns it to the correct result.
- Restart after HALT: start plus simultaneous prog_we rewriting word 0 -> new instruction executed first; flags from the previous run retained until the first ADD/SUB.
